hall_call_register: RTL and testbench

- Upstream stage of the dual-elevator dispatcher. Takes raw, bouncy hall (outer) call buttons for floors 1..5.
- Debounces each button and latches it as a pending call. The call is held until one of the two elevators is stopped at that floor.
- Drives the dispatcher's out_buttons input with clean, level pending-call flags.
- One independent per-floor state machine plus a debounce counter for each floor.

---
 rtl/hall_call_register.sv | 121 ++++++++++++
 tb/tb_hall_call_register.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/hall_call_register.sv
// Hall call register: debounces raw hall buttons per floor, latches them as pending
// calls, and retires each call once an elevator is stopped at that floor.
module hall_call_register #(
  parameter int NUM_FLOORS      = 5,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] raw_buttons,
  input  logic [2:0]            ffloor,
  input  logic                  fgoing_up,
  input  logic                  fgoing_down,
  input  logic [2:0]            sfloor,
  input  logic                  sgoing_up,
  input  logic                  sgoing_down,
  output logic [NUM_FLOORS-1:0] out_buttons,
  output logic [NUM_FLOORS-1:0] served
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PENDING  = 2'd2,
    RELEASE  = 2'd3
  } call_state_e;

  // Per-floor state is kept in plain arrays so each floor can be probed directly.
  call_state_e           state_q [NUM_FLOORS];
  call_state_e           state_d [NUM_FLOORS];
  logic [CNT_W-1:0]      cnt_q   [NUM_FLOORS];
  logic [CNT_W-1:0]      cnt_d   [NUM_FLOORS];
  logic [NUM_FLOORS-1:0] out_buttons_q, out_buttons_d;
  logic [NUM_FLOORS-1:0] served_q, served_d;
  logic [NUM_FLOORS-1:0] stopped;
  logic [NUM_FLOORS-1:0] accept;

  // Floor codes outside 1..NUM_FLOORS never compare equal to any floor index.
  always_comb begin
    stopped = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      stopped[i] = ((int'(ffloor) == i + 1) && !fgoing_up && !fgoing_down) ||
                   ((int'(sfloor) == i + 1) && !sgoing_up && !sgoing_down);
    end
  end

  always_comb begin
    accept        = '0;
    out_buttons_d = '0;
    served_d      = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      unique case (state_q[i])
        IDLE: begin
          if (raw_buttons[i]) begin
            if (DEBOUNCE_CYCLES == 1) begin
              accept[i] = 1'b1;
            end else begin
              state_d[i] = DEBOUNCE;
              cnt_d[i]   = CNT_W'(1);
            end
          end
        end
        DEBOUNCE: begin
          if (!raw_buttons[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            accept[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
          end
        end
        PENDING: begin
          if (stopped[i]) begin
            served_d[i] = 1'b1;
            state_d[i]  = raw_buttons[i] ? RELEASE : IDLE;
          end
        end
        RELEASE: begin
          if (!raw_buttons[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase

      // A call accepted while an elevator already stands at the floor is absorbed.
      if (accept[i]) begin
        cnt_d[i] = '0;
        if (stopped[i]) begin
          state_d[i]  = RELEASE;
          served_d[i] = 1'b1;
        end else begin
          state_d[i] = PENDING;
        end
      end

      out_buttons_d[i] = (state_d[i] == PENDING);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_FLOORS; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      out_buttons_q <= '0;
      served_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_buttons_q <= out_buttons_d;
      served_q      <= served_d;
    end
  end

  assign out_buttons = out_buttons_q;
  assign served      = served_q;

endmodule

// File: tb/tb_hall_call_register.sv
// Bench for hall_call_register: directed scenarios plus random traffic, checked every
// cycle against a run-length based model of pending hall calls.
module tb_hall_call_register;

  localparam int NF = 5;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] raw_buttons;
  logic [2:0]    ffloor, sfloor;
  logic          fgoing_up, fgoing_down, sgoing_up, sgoing_down;
  logic [NF-1:0] out_buttons, served;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model: consecutive-high run length, pending flag, waiting-for-release flag.
  int            high_run [NF];
  bit            pend     [NF];
  bit            wrel     [NF];
  logic [2*NF-1:0] exp_q [$];

  hall_call_register #(.NUM_FLOORS(NF), .DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .raw_buttons(raw_buttons),
    .ffloor(ffloor), .fgoing_up(fgoing_up), .fgoing_down(fgoing_down),
    .sfloor(sfloor), .sgoing_up(sgoing_up), .sgoing_down(sgoing_down),
    .out_buttons(out_buttons), .served(served)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit stop_at(int k, logic [2:0] ff, logic fu, logic fd,
                                 logic [2:0] sf, logic su, logic sd);
    return (int'(ff) == k && !fu && !fd) || (int'(sf) == k && !su && !sd);
  endfunction

  task automatic model_edge(input logic rst, input logic [NF-1:0] raw,
                            input logic [2:0] ff, input logic fu, input logic fd,
                            input logic [2:0] sf, input logic su, input logic sd);
    logic [NF-1:0] e_out, e_srv;
    e_out = '0;
    e_srv = '0;
    for (int i = 0; i < NF; i++) begin
      bit here;
      here = stop_at(i + 1, ff, fu, fd, sf, su, sd);
      if (rst) begin
        high_run[i] = 0; pend[i] = 0; wrel[i] = 0;
      end else if (pend[i]) begin
        if (here) begin
          e_srv[i] = 1'b1; pend[i] = 0; wrel[i] = raw[i];
        end
      end else if (wrel[i]) begin
        if (!raw[i]) wrel[i] = 0;
      end else begin
        high_run[i] = raw[i] ? high_run[i] + 1 : 0;
        if (high_run[i] == DB) begin
          high_run[i] = 0;
          if (here) begin
            e_srv[i] = 1'b1; wrel[i] = 1;
          end else begin
            pend[i] = 1;
          end
        end
      end
      e_out[i] = pend[i];
    end
    exp_q.push_back({e_srv, e_out});
  endtask

  task automatic step(input logic rst, input logic [NF-1:0] raw,
                      input logic [2:0] ff, input logic fu, input logic fd,
                      input logic [2:0] sf, input logic su, input logic sd);
    logic [2*NF-1:0] exp;
    @(negedge clk);
    reset = rst; raw_buttons = raw;
    ffloor = ff; fgoing_up = fu; fgoing_down = fd;
    sfloor = sf; sgoing_up = su; sgoing_down = sd;
    @(posedge clk);
    model_edge(rst, raw, ff, fu, fd, sf, su, sd);
    #1;
    exp = exp_q.pop_front();
    check("out_buttons", 16'(out_buttons), 16'(exp[NF-1:0]));
    check("served", 16'(served), 16'(exp[2*NF-1:NF]));
  endtask

  // Both elevators moving up at floor 1: nothing can be served.
  task automatic step_moving(input logic rst, input logic [NF-1:0] raw);
    step(rst, raw, 3'd1, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
  endtask

  initial begin
    logic [NF-1:0] bounce_pat;
    logic [NF-1:0] rnd_raw;
    bounce_pat = 5'b00100;
    reset = 1'b1; raw_buttons = '0;
    ffloor = 3'd1; sfloor = 3'd1;
    fgoing_up = 1'b1; fgoing_down = 1'b0; sgoing_up = 1'b1; sgoing_down = 1'b0;

    // 1: reset with all buttons held, then accept after 4 edges.
    step_moving(1'b1, 5'b11111);
    step_moving(1'b1, 5'b11111);
    check("t1_reset_out", 16'(out_buttons), 16'h0);
    for (int i = 0; i < 3; i++) step_moving(1'b0, 5'b11111);
    check("t1_before_accept", 16'(out_buttons), 16'h0);
    step_moving(1'b0, 5'b11111);
    check("t1_accept", 16'(out_buttons), 16'h1f);

    // 2: bounce on floor 3 restarts the count.
    step_moving(1'b1, 5'b00000);
    for (int i = 0; i < 7; i++) begin
      step_moving(1'b0, (i == 2) ? 5'b00000 : bounce_pat);
      if (i == 5) check("t2_no_early", 16'(out_buttons), 16'h0);
    end
    check("t2_accept", 16'(out_buttons), 16'h04);

    // 3: passing through floor 3 does not serve; stopping does.
    for (int i = 0; i < 3; i++) step(1'b0, 5'b0, 3'd3, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0);
    check("t3_passing", 16'(out_buttons), 16'h04);
    step(1'b0, 5'b0, 3'd3, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0);
    check("t3_served", 16'(served), 16'h04);
    check("t3_cleared", 16'(out_buttons), 16'h0);
    step_moving(1'b0, 5'b0);
    check("t3_one_pulse", 16'(served), 16'h0);

    // 4: press at a floor where elevator 2 is idle is absorbed.
    for (int i = 0; i < 4; i++) step(1'b0, 5'b00010, 3'd4, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0);
    check("t4_absorbed", 16'(served), 16'h02);
    check("t4_no_call", 16'(out_buttons), 16'h0);
    for (int i = 0; i < 20; i++) step_moving(1'b0, 5'b00010);
    check("t4_held", 16'(out_buttons), 16'h0);
    step_moving(1'b0, 5'b00000);
    for (int i = 0; i < 4; i++) step_moving(1'b0, 5'b00010);
    check("t4_repress", 16'(out_buttons), 16'h02);

    // 5: floors 1 and 5 served together by different elevators.
    step_moving(1'b1, 5'b00000);
    for (int i = 0; i < 4; i++) step(1'b0, 5'b10001, 3'd2, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1);
    check("t5_pending", 16'(out_buttons), 16'h11);
    step(1'b0, 5'b00000, 3'd1, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0);
    check("t5_served", 16'(served), 16'h11);
    check("t5_cleared", 16'(out_buttons), 16'h0);

    // 6: reset drops a pending call on floor 4.
    for (int i = 0; i < 4; i++) step_moving(1'b0, 5'b01000);
    check("t6_pending", 16'(out_buttons), 16'h08);
    step_moving(1'b1, 5'b00000);
    for (int i = 0; i < 5; i++) step_moving(1'b0, 5'b00000);
    check("t6_dropped", 16'(out_buttons), 16'h0);

    // Random traffic: buttons mostly hold their level, elevators wander.
    rnd_raw = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < NF; b++)
        if ($urandom_range(0, 7) == 0) rnd_raw[b] = ~rnd_raw[b];
      step(($urandom_range(0, 199) == 0), rnd_raw,
           3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
